// File: rtl/sevga_pkg.sv
// Shared types and widths for the SE-VGA VRAM arbiter and its write queue.
// Contents: bus widths, queue sizing, fetch slot position, FSM state
// encoding, the queued write payload and the chip-select decoder.
package sevga_pkg;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_BUFS   = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FETCH_SLOT = 3;
    localparam int unsigned SEQ_LEN    = 8;

    localparam int unsigned SEQ_W = $clog2(SEQ_LEN);
    localparam int unsigned BUF_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WSETUP,
        WSTROBE
    } arb_state_t;

    // One snooped CPU write waiting for a free slot
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BUF_W-1:0]  buf_idx;
    } wr_entry_t;

    // Active-low one-cold select; an out-of-range index selects nothing
    function automatic logic [NUM_BUFS-1:0] ce_decode(input logic [BUF_W-1:0] sel);
        logic [NUM_BUFS-1:0] ce;
        ce = '1;
        for (int unsigned i = 0; i < NUM_BUFS; i++) begin
            if (sel == BUF_W'(i)) begin
                ce[i] = 1'b0;
            end
        end
        return ce;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO holding CPU writes until the arbiter can retire them.
// Ports: clk, rst (sync, active-high flush), push/wr_entry (enqueue),
// pop/head (dequeue, head is the oldest entry), full, empty, count.
// Build option VRAM_WR_COALESCE_EN adds coalesce (overwrite the newest
// entry's data instead of pushing) and newest (the most recent entry).
module vram_wr_fifo
    import sevga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
`ifdef VRAM_WR_COALESCE_EN
    input  logic             coalesce,
    output wr_entry_t        newest,
`endif
    input  wr_entry_t        wr_entry,
    output wr_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wr_entry_t        mem_q [FIFO_DEPTH];
    wr_entry_t        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer/count update; caller guarantees push only when space and pop only when non-empty
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
`ifdef VRAM_WR_COALESCE_EN
        if (coalesce) begin
            mem_d[wptr_q - PTR_W'(1)].data = wr_entry.data;
        end
`endif
        if (push) begin
            mem_d[wptr_q] = wr_entry;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rptr_q];
`ifdef VRAM_WR_COALESCE_EN
    assign newest = mem_q[wptr_q - PTR_W'(1)];
`endif
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: the video fetch owns its slot of the 8-pixel sequence,
// queued CPU writes retire in the remaining slots as a setup + strobe pair.
// Ports: pixClk/reset (sync, active-high); seq = hCount[2:0];
// wrValid/wrReady/wrAddr/wrData/wrBuf = CPU write queue input;
// vidReq/vidAddr/vidBuf -> vidData/vidDataValid = video fetch;
// vramAddr/vramDataOut/vramDataOE/vramDataIn/nvramOE/nvramWE/nvramCE = SRAM pins.
// Build option VRAM_WR_COALESCE_EN merges a write into the newest queued
// entry when address and buffer match.
module vram_arbiter
    import sevga_pkg::*;
(
    input  logic                pixClk,
    input  logic                reset,
    input  logic [SEQ_W-1:0]    seq,
    input  logic                wrValid,
    output logic                wrReady,
    input  logic [ADDR_W-1:0]   wrAddr,
    input  logic [DATA_W-1:0]   wrData,
    input  logic [BUF_W-1:0]    wrBuf,
    input  logic                vidReq,
    input  logic [ADDR_W-1:0]   vidAddr,
    input  logic [BUF_W-1:0]    vidBuf,
    output logic [DATA_W-1:0]   vidData,
    output logic                vidDataValid,
    output logic [ADDR_W-1:0]   vramAddr,
    output logic [DATA_W-1:0]   vramDataOut,
    output logic                vramDataOE,
    input  logic [DATA_W-1:0]   vramDataIn,
    output logic                nvramOE,
    output logic                nvramWE,
    output logic [NUM_BUFS-1:0] nvramCE
);

    arb_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0]   vram_dout_q, vram_dout_d;
    logic                vram_doe_q, vram_doe_d;
    logic                noe_q, noe_d;
    logic                nwe_q, nwe_d;
    logic [NUM_BUFS-1:0] nce_q, nce_d;
    logic [DATA_W-1:0]   vid_data_q, vid_data_d;
    logic                vid_valid_q, vid_valid_d;
    logic                wr_ready_q, wr_ready_d;

    logic [SEQ_W-1:0]    seq_p1, seq_p2;
    logic                fetch_due, write_ok;
    logic                wr_push, push_eff, coalesce, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count, count_nxt;
    wr_entry_t           wr_in, fifo_head;
`ifdef VRAM_WR_COALESCE_EN
    wr_entry_t           fifo_newest;
    logic                newest_match;
`endif

    assign wr_in = '{addr: wrAddr, data: wrData, buf_idx: wrBuf};

    vram_wr_fifo u_fifo (
        .clk      (pixClk),
        .rst      (reset),
        .push     (push_eff),
        .pop      (fifo_pop),
`ifdef VRAM_WR_COALESCE_EN
        .coalesce (coalesce),
        .newest   (fifo_newest),
`endif
        .wr_entry (wr_in),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Next state: the state chosen now occupies seq+1. A write needs seq+1 and seq+2 clear of the fetch.
    // A fetch that becomes due mid-write pre-empts the strobe; the popped entry is lost.
    always_comb begin
        seq_p1    = seq + SEQ_W'(1);
        seq_p2    = seq + SEQ_W'(2);
        fetch_due = vidReq && (seq_p1 == SEQ_W'(FETCH_SLOT));
        write_ok  = !fifo_empty && !(vidReq && (seq_p2 == SEQ_W'(FETCH_SLOT)));

        state_d = IDLE;
        if (fetch_due) begin
            state_d = FETCH;
        end else if (state_q == WSETUP) begin
            state_d = WSTROBE;
        end else if (write_ok) begin
            state_d = WSETUP;
        end
        fifo_pop = (state_d == WSETUP);
    end

    // Write queue acceptance and registered ready
    always_comb begin
        wr_push = wrValid && wr_ready_q;
`ifdef VRAM_WR_COALESCE_EN
        newest_match = !fifo_empty && (fifo_newest.addr == wrAddr) &&
                       (fifo_newest.buf_idx == wrBuf);
        // A sole entry leaving this edge cannot absorb the write
        coalesce     = wr_push && newest_match &&
                       !(fifo_pop && (fifo_count == CNT_W'(1)));
`else
        coalesce     = 1'b0;
`endif
        push_eff  = wr_push && !coalesce && (!fifo_full || fifo_pop);
        count_nxt = fifo_count + CNT_W'(push_eff) - CNT_W'(fifo_pop);
`ifdef VRAM_WR_COALESCE_EN
        // When full the newest entry can never be the one popped, so a match can always merge
        wr_ready_d = (count_nxt != CNT_W'(FIFO_DEPTH)) || wr_push || newest_match;
`else
        wr_ready_d = (count_nxt != CNT_W'(FIFO_DEPTH));
`endif
    end

    // SRAM pin values for the cycle the next state occupies
    always_comb begin
        noe_d       = 1'b1;
        nwe_d       = 1'b1;
        nce_d       = '1;
        vram_doe_d  = 1'b0;
        vram_addr_d = vram_addr_q;
        vram_dout_d = vram_dout_q;
        case (state_d)
            FETCH: begin
                noe_d       = 1'b0;
                nce_d       = ce_decode(vidBuf);
                vram_addr_d = vidAddr;
            end
            WSETUP: begin
                nce_d       = ce_decode(fifo_head.buf_idx);
                vram_addr_d = fifo_head.addr;
                vram_dout_d = fifo_head.data;
                vram_doe_d  = 1'b1;
            end
            WSTROBE: begin
                nce_d       = nce_q;
                vram_doe_d  = 1'b1;
                nwe_d       = 1'b0;
            end
            default: ;
        endcase

        // Capture read data as FETCH ends; a fetch with no chip selected is dropped
        vid_data_d  = vid_data_q;
        vid_valid_d = 1'b0;
        if ((state_q == FETCH) && !(&nce_q)) begin
            vid_data_d  = vramDataIn;
            vid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge pixClk) begin
        if (reset) begin
            state_q     <= IDLE;
            vram_addr_q <= '0;
            vram_dout_q <= '0;
            vram_doe_q  <= 1'b0;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            nce_q       <= '1;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vram_addr_q <= vram_addr_d;
            vram_dout_q <= vram_dout_d;
            vram_doe_q  <= vram_doe_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
            nce_q       <= nce_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    assign wrReady      = wr_ready_q;
    assign vidData      = vid_data_q;
    assign vidDataValid = vid_valid_q;
    assign vramAddr     = vram_addr_q;
    assign vramDataOut  = vram_dout_q;
    assign vramDataOE   = vram_doe_q;
    assign nvramOE      = noe_q;
    assign nvramWE      = nwe_q;
    assign nvramCE      = nce_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, fetch timing, single write,
// queue back-pressure and ordering, reset during a strobe, and write
// merging (expectation depends on VRAM_WR_COALESCE_EN).
module tb_vram_arbiter;
    import sevga_pkg::*;

    logic                pixClk = 1'b0;
    logic                reset;
    logic [SEQ_W-1:0]    seq;
    logic                wrValid;
    logic                wrReady;
    logic [ADDR_W-1:0]   wrAddr;
    logic [DATA_W-1:0]   wrData;
    logic [BUF_W-1:0]    wrBuf;
    logic                vidReq;
    logic [ADDR_W-1:0]   vidAddr;
    logic [BUF_W-1:0]    vidBuf;
    logic [DATA_W-1:0]   vidData;
    logic                vidDataValid;
    logic [ADDR_W-1:0]   vramAddr;
    logic [DATA_W-1:0]   vramDataOut;
    logic                vramDataOE;
    logic [DATA_W-1:0]   vramDataIn;
    logic                nvramOE;
    logic                nvramWE;
    logic [NUM_BUFS-1:0] nvramCE;

    int vectors     = 0;
    int miscompares = 0;
    int slot_viol   = 0;
    int overlap     = 0;
    int missed_fetch = 0;
    bit mon_fetch   = 1'b0;
    logic [31:0] wr_log [$];
    int acc;
    int n;
    logic rdy;

    always #5 pixClk = ~pixClk;

    vram_arbiter dut (
        .pixClk       (pixClk),
        .reset        (reset),
        .seq          (seq),
        .wrValid      (wrValid),
        .wrReady      (wrReady),
        .wrAddr       (wrAddr),
        .wrData       (wrData),
        .wrBuf        (wrBuf),
        .vidReq       (vidReq),
        .vidAddr      (vidAddr),
        .vidBuf       (vidBuf),
        .vidData      (vidData),
        .vidDataValid (vidDataValid),
        .vramAddr     (vramAddr),
        .vramDataOut  (vramDataOut),
        .vramDataOE   (vramDataOE),
        .vramDataIn   (vramDataIn),
        .nvramOE      (nvramOE),
        .nvramWE      (nvramWE),
        .nvramCE      (nvramCE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_rec(input logic [1:0] ce, input logic [14:0] a,
                                           input logic [7:0] d);
        return 32'({ce, a, d});
    endfunction

    // One pixel clock: outputs sampled 1 time unit after the edge, seq advanced for the new cycle
    task automatic step();
        @(posedge pixClk);
        #1;
        seq = seq + 3'd1;
        if (!nvramWE) wr_log.push_back(32'({nvramCE, vramAddr, vramDataOut}));
        if (!nvramWE && !nvramOE) overlap++;
        if (mon_fetch && (seq == 3'(FETCH_SLOT))) begin
            if (!nvramWE || vramDataOE) slot_viol++;
            if (nvramOE) missed_fetch++;
        end
    endtask

    task automatic wait_seq(input logic [2:0] v);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((seq != v) && (k < 16));
    endtask

    initial begin
        reset      = 1'b1;
        seq        = 3'd0;
        wrValid    = 1'b1;
        wrAddr     = 15'h7FFF;
        wrData     = 8'hFF;
        wrBuf      = 1'b1;
        vidReq     = 1'b0;
        vidAddr    = '0;
        vidBuf     = '0;
        vramDataIn = '0;

        // 1: reset held with a pending write
        repeat (3) step();
        check("rst_noe",     32'(nvramOE), 1);
        check("rst_nwe",     32'(nvramWE), 1);
        check("rst_nce",     32'(nvramCE), 32'h3);
        check("rst_doe",     32'(vramDataOE), 0);
        check("rst_addr",    32'(vramAddr), 0);
        check("rst_dout",    32'(vramDataOut), 0);
        check("rst_viddata", 32'(vidData), 0);
        check("rst_vidval",  32'(vidDataValid), 0);
        check("rst_ready",   32'(wrReady), 0);
        wrValid = 1'b0;
        reset   = 1'b0;
        wr_log.delete();
        repeat (8) step();
        check("rst_nothing_queued", 32'(wr_log.size()), 0);
        check("post_rst_ready", 32'(wrReady), 1);

        // 2: video fetch, empty queue
        vidReq     = 1'b1;
        vidAddr    = 15'h1234;
        vidBuf     = 1'b1;
        vramDataIn = 8'hA5;
        mon_fetch  = 1'b1;
        wait_seq(3'd3);
        check("fetch_noe",  32'(nvramOE), 0);
        check("fetch_nce",  32'(nvramCE), 32'h1);
        check("fetch_addr", 32'(vramAddr), 32'h1234);
        check("fetch_nwe",  32'(nvramWE), 1);
        step();
        check("fetch_data",  32'(vidData), 32'hA5);
        check("fetch_valid", 32'(vidDataValid), 1);

        // 3: one write enters the queue at seq 5
        check("w1_ready", 32'(wrReady), 1);
        wrValid    = 1'b1;
        wrAddr     = 15'h0042;
        wrData     = 8'h5A;
        wrBuf      = 1'b0;
        vramDataIn = 8'h00;
        step();
        wrValid = 1'b0;
        check("fetch_pulse_end", 32'(vidDataValid), 0);
        wr_log.delete();
        step();
        check("w1_setup_seq", 32'(seq), 6);
        check("w1_setup_doe", 32'(vramDataOE), 1);
        check("w1_setup_nwe", 32'(nvramWE), 1);
        check("w1_setup_nce", 32'(nvramCE), 32'h2);
        check("w1_setup_addr", 32'(vramAddr), 32'h42);
        check("w1_setup_dout", 32'(vramDataOut), 32'h5A);
        step();
        check("w1_strobe_nwe", 32'(nvramWE), 0);
        check("w1_strobe_nce", 32'(nvramCE), 32'h2);
        check("w1_strobe_doe", 32'(vramDataOE), 1);
        check("w1_strobe_noe", 32'(nvramOE), 1);
        step();
        check("w1_done_nwe", 32'(nvramWE), 1);
        check("w1_done_doe", 32'(vramDataOE), 0);
        check("w1_write_count", 32'(wr_log.size()), 1);

        // 4: five writes offered every cycle from seq 0
        wr_log.delete();
        acc = 0;
        n   = 0;
        while ((acc < 5) && (n < 40)) begin
            wrValid = 1'b1;
            wrAddr  = 15'(15'h100 + acc);
            wrData  = 8'(8'h30 + acc);
            wrBuf   = 1'(acc);
            rdy     = wrReady;
            step();
            n++;
            if (rdy) acc++;
        end
        wrValid = 1'b0;
        check("q_accepts", 32'(acc), 5);
        // First entry already left for the seq-4 write, so four remain queued and ready drops at seq 5
        check("q_full_seq", 32'(seq), 5);
        check("q_full_ready", 32'(wrReady), 0);
        step();
        check("q_ready_back", 32'(wrReady), 1);
        n = 0;
        while ((wr_log.size() < 5) && (n < 40)) begin
            step();
            n++;
        end
        check("q_write_count", 32'(wr_log.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_log.size()) begin
                check($sformatf("q_order_%0d", i), wr_log[i],
                      wr_rec((i % 2 == 1) ? 2'b01 : 2'b10, 15'(15'h100 + i), 8'(8'h30 + i)));
            end
        end
        check("q_no_slot_write", 32'(slot_viol), 0);
        check("q_fetch_each_slot", 32'(missed_fetch), 0);
        check("q_oe_we_overlap", 32'(overlap), 0);

        // 5: reset during the strobe of the first of two queued writes
        vidReq    = 1'b0;
        mon_fetch = 1'b0;
        repeat (2) step();
        wrValid = 1'b1;
        wrAddr  = 15'h0200;
        wrData  = 8'h77;
        wrBuf   = 1'b0;
        step();
        wrAddr  = 15'h0201;
        wrData  = 8'h78;
        step();
        wrValid = 1'b0;
        check("r_setup_doe",  32'(vramDataOE), 1);
        check("r_setup_addr", 32'(vramAddr), 32'h200);
        step();
        check("r_strobe_nwe", 32'(nvramWE), 0);
        reset = 1'b1;
        step();
        check("r_nwe",   32'(nvramWE), 1);
        check("r_doe",   32'(vramDataOE), 0);
        check("r_nce",   32'(nvramCE), 32'h3);
        check("r_ready", 32'(wrReady), 0);
        reset = 1'b0;
        wr_log.delete();
        repeat (10) step();
        check("r_flushed", 32'(wr_log.size()), 0);
        check("r_idle_doe", 32'(vramDataOE), 0);

        // 6: same-address writes while the fetch blocks the bus
        vidReq    = 1'b1;
        mon_fetch = 1'b1;
        wait_seq(3'd1);
        wr_log.delete();
        wrValid = 1'b1;
        wrAddr  = 15'h0010;
        wrData  = 8'h11;
        wrBuf   = 1'b0;
        step();
        wrData  = 8'h22;
        step();
        wrValid = 1'b0;
        wait_seq(3'd0);
`ifdef VRAM_WR_COALESCE_EN
        check("c_write_count", 32'(wr_log.size()), 1);
        if (wr_log.size() > 0) check("c_write0", wr_log[0], wr_rec(2'b10, 15'h0010, 8'h22));
`else
        check("c_write_count", 32'(wr_log.size()), 2);
        if (wr_log.size() > 0) check("c_write0", wr_log[0], wr_rec(2'b10, 15'h0010, 8'h11));
        if (wr_log.size() > 1) check("c_write1", wr_log[1], wr_rec(2'b10, 15'h0010, 8'h22));
`endif
        check("c_oe_we_overlap", 32'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
